// File: rtl/spi_receiver_pkg.sv
// -----------------------------------------------------------------------------
// spi_receiver_pkg : shared line-coding encodings, states and helpers  (rev 1.0)
// -----------------------------------------------------------------------------
`default_nettype none

package spi_receiver_pkg;

   localparam logic [1:0] DB_5 = 2'b00;
   localparam logic [1:0] DB_6 = 2'b01;
   localparam logic [1:0] DB_7 = 2'b10;
   localparam logic [1:0] DB_8 = 2'b11;

   localparam logic [1:0] PAR_EVEN = 2'b00;
   localparam logic [1:0] PAR_ODD  = 2'b01;
   localparam logic [1:0] PAR_ZERO = 2'b10;
   localparam logic [1:0] PAR_ONE  = 2'b11;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP1  = 3'd4;
   localparam logic [2:0] ST_STOP2  = 3'd5;

   localparam int unsigned OVERSAMPLE = 16;
   localparam logic [3:0]  MID_TICK   = 4'(OVERSAMPLE / 2 - 1);
   localparam logic [3:0]  LAST_TICK  = 4'(OVERSAMPLE - 1);

   function automatic logic [3:0] data_width(input logic [1:0] db);
      case (db)
         DB_5:    return 4'd5;
         DB_6:    return 4'd6;
         DB_7:    return 4'd7;
         DB_8:    return 4'd8;
         default: return 4'd8;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/spi_baudgen.sv
// -----------------------------------------------------------------------------
// spi_baudgen : oversample prescaler, one-clock tick every clk_div+1 clocks  (rev 1.0)
// -----------------------------------------------------------------------------
`default_nettype none

module spi_baudgen (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [15:0] clk_div,
   output logic        tick
);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   // Held at the reload value while idle so the first tick is a full period away
   always_comb begin
      cnt_d = cnt_q;
      if (!en || (cnt_q == 16'd0)) begin
         cnt_d = clk_div;
      end else begin
         cnt_d = cnt_q - 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= 16'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = en && (cnt_q == 16'd0);

endmodule

`default_nettype wire

// File: rtl/spi_receiver.sv
// -----------------------------------------------------------------------------
// spi_receiver : start/data/parity/stop framed receiver with holding register  (rev 1.0)
// -----------------------------------------------------------------------------
`default_nettype none

module spi_receiver
   import spi_receiver_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [15:0] clk_div,
   input  logic [1:0]  data_bits,
   input  logic        par_enable,
   input  logic [1:0]  par_type,
   input  logic        stop_bits,
   input  logic        spi_MISO,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic        par_err,
   output logic        frm_err,
   output logic        ovr_err,
   output logic        busy
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [2:0]             state_q, state_d;
   logic [3:0]             tcnt_q, bitcnt_q;
   logic [7:0]             shreg_q;
   logic                   par_pend_q, frm_pend_q;
   logic [7:0]             data_q, data_d;
   logic                   valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d, oerr_q, oerr_d;
   logic                   rxs, tick, sample, done, mid_start, par_exp;
   logic [3:0]             width;
   logic [7:0]             word;

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], spi_MISO};
      end
   end
   assign rxs = sync_q[SYNC_STAGES-1];

   spi_baudgen u_baudgen (
      .clk     (clk),
      .rst     (rst),
      .en      (busy),
      .clk_div (clk_div),
      .tick    (tick)
   );

   assign width = data_width(data_bits);
   // Bits were shifted in from the top, so realign to the LSB for short words
   assign word  = shreg_q >> (4'd8 - width);

   always_comb begin
      par_exp = 1'b0;
      case (par_type)
         PAR_EVEN: par_exp = ^word;
         PAR_ODD:  par_exp = ~(^word);
         PAR_ZERO: par_exp = 1'b0;
         PAR_ONE:  par_exp = 1'b1;
         default:  par_exp = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if ((state_q != ST_IDLE) && !enable) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:   if (enable && !rxs) state_d = ST_START;
            ST_START:  if (mid_start) state_d = rxs ? ST_IDLE : ST_DATA;
            ST_DATA:   if (sample && (bitcnt_q == 4'd0)) state_d = par_enable ? ST_PARITY : ST_STOP1;
            ST_PARITY: if (sample) state_d = ST_STOP1;
            ST_STOP1:  if (sample) state_d = stop_bits ? ST_STOP2 : ST_IDLE;
            ST_STOP2:  if (sample) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      busy      = (state_q != ST_IDLE);
      mid_start = tick && (state_q == ST_START) && (tcnt_q == MID_TICK);
      sample    = tick && (tcnt_q == LAST_TICK) && busy && (state_q != ST_START);
      done      = sample && enable &&
                  (((state_q == ST_STOP1) && !stop_bits) || (state_q == ST_STOP2));
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         tcnt_q     <= 4'd0;
         bitcnt_q   <= 4'd0;
         shreg_q    <= 8'd0;
         par_pend_q <= 1'b0;
         frm_pend_q <= 1'b0;
      end else begin
         if (!busy || mid_start) begin
            tcnt_q <= 4'd0;
         end else if (tick) begin
            tcnt_q <= tcnt_q + 4'd1;
         end
         if (!busy) begin
            par_pend_q <= 1'b0;
            frm_pend_q <= 1'b0;
            bitcnt_q   <= width - 4'd1;
         end else if (sample) begin
            case (state_q)
               ST_DATA: begin
                  shreg_q  <= {rxs, shreg_q[7:1]};
                  bitcnt_q <= bitcnt_q - 4'd1;
               end
               ST_PARITY:          if (rxs != par_exp) par_pend_q <= 1'b1;
               ST_STOP1, ST_STOP2: if (!rxs) frm_pend_q <= 1'b1;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      data_d  = data_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      oerr_d  = oerr_q;
      valid_d = valid_q && !rx_ready;
      if (done) begin
         data_d  = word;
         perr_d  = par_pend_q;
         ferr_d  = frm_pend_q || !rxs;
         oerr_d  = valid_q && !rx_ready;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         data_q  <= 8'd0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         oerr_q  <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         oerr_q  <= oerr_d;
      end
   end

   assign rx_data  = data_q;
   assign rx_valid = valid_q;
   assign par_err  = perr_q;
   assign frm_err  = ferr_q;
   assign ovr_err  = oerr_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_receiver.sv
// -----------------------------------------------------------------------------
// tb_spi_receiver : directed scoreboard bench for spi_receiver  (rev 1.0)
// -----------------------------------------------------------------------------
`default_nettype none

module tb_spi_receiver;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enable = 1'b0;
   logic [15:0] clk_div = 16'd0;
   logic [1:0]  data_bits = 2'b11;
   logic        par_enable = 1'b0;
   logic [1:0]  par_type = 2'b00;
   logic        stop_bits = 1'b0;
   logic        spi_MISO = 1'b1;
   logic        rx_ready = 1'b0;
   logic [7:0]  rx_data;
   logic        rx_valid, par_err, frm_err, ovr_err, busy;

   spi_receiver #(.SYNC_STAGES(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .clk_div    (clk_div),
      .data_bits  (data_bits),
      .par_enable (par_enable),
      .par_type   (par_type),
      .stop_bits  (stop_bits),
      .spi_MISO   (spi_MISO),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .par_err    (par_err),
      .frm_err    (frm_err),
      .ovr_err    (ovr_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] data;
      logic       par;
      logic       frm;
      logic       ovr;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   bit   m_valid = 1'b0;

   int   rise_cnt = 0;
   logic prev_valid = 1'b0, prev_busy = 1'b0;
   logic rise_busy_before = 1'b0, rise_busy_now = 1'b1;

   // Records the busy level around every rx_valid rising edge
   always @(negedge clk) begin
      if (rx_valid && !prev_valid) begin
         rise_cnt         <= rise_cnt + 1;
         rise_busy_before <= prev_busy;
         rise_busy_now    <= busy;
      end
      prev_valid <= rx_valid;
      prev_busy  <= busy;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic par_bit(input logic [7:0] d, input int n, input logic [1:0] pt);
      logic x = 1'b0;
      for (int i = 0; i < n; i++) x ^= d[i];
      case (pt)
         2'b00:   return x;
         2'b01:   return ~x;
         2'b10:   return 1'b0;
         default: return 1'b1;
      endcase
   endfunction

   task automatic send_frame(input logic [7:0] d, input int n, input bit bad_par,
                             input bit bad_stop, input bit rdy_on_done);
      int   bt = 16 * (int'(clk_div) + 1);
      int   m  = n + int'(par_enable) + (stop_bits ? 2 : 1);
      int   k  = 3 + (8 + 16 * m) * (int'(clk_div) + 1);
      logic pb = par_bit(d, n, par_type) ^ bad_par;
      exp_t e;
      e.data = d & 8'((1 << n) - 1);
      e.par  = bad_par && par_enable;
      e.frm  = bad_stop;
      e.ovr  = m_valid && !rdy_on_done;
      sb.push_back(e);
      m_valid = 1'b1;
      fork
         begin
            @(negedge clk);
            spi_MISO = 1'b0;
            repeat (bt) @(negedge clk);
            for (int i = 0; i < n; i++) begin
               spi_MISO = d[i];
               repeat (bt) @(negedge clk);
            end
            if (par_enable) begin
               spi_MISO = pb;
               repeat (bt) @(negedge clk);
            end
            spi_MISO = !bad_stop;
            repeat (bt) @(negedge clk);
            if (stop_bits) begin
               spi_MISO = 1'b1;
               repeat (bt) @(negedge clk);
            end
            spi_MISO = 1'b1;
            repeat (bt) @(negedge clk);
         end
         begin
            if (rdy_on_done) begin
               @(negedge clk);
               repeat (k - 1) @(posedge clk);
               @(negedge clk);
               rx_ready = 1'b1;
               @(negedge clk);
               rx_ready = 1'b0;
            end
         end
      join
   endtask

   task automatic check_word(input string tag);
      exp_t e;
      int   w = 0;
      e = sb.pop_front();
      while (busy && w < 5000) begin
         @(negedge clk);
         w++;
      end
      chk({tag, "_idle"}, busy, 0);
      chk({tag, "_valid"}, rx_valid, 1);
      chk({tag, "_data"}, rx_data, e.data);
      chk({tag, "_par"}, par_err, e.par);
      chk({tag, "_frm"}, frm_err, e.frm);
      chk({tag, "_ovr"}, ovr_err, e.ovr);
   endtask

   task automatic consume(input string tag);
      @(negedge clk);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      m_valid  = 1'b0;
      chk({tag, "_consumed"}, rx_valid, 0);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_data"}, rx_data, 0);
      chk({tag, "_valid"}, rx_valid, 0);
      chk({tag, "_par"}, par_err, 0);
      chk({tag, "_frm"}, frm_err, 0);
      chk({tag, "_ovr"}, ovr_err, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      int base;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst    = 1'b1;
      enable = 1'b1;
      repeat (4) @(negedge clk);

      // 8N1, fastest prescaler
      base = rise_cnt;
      send_frame(8'hA5, 8, 0, 0, 0);
      check_word("a5");
      chk("a5_rises", rise_cnt - base, 1);
      chk("a5_busy_before_rise", rise_busy_before, 1);
      chk("a5_busy_at_rise", rise_busy_now, 0);
      consume("a5");

      // 7E2 with a wrong parity bit
      clk_div = 16'd3; data_bits = 2'b10; par_enable = 1'b1; par_type = 2'b00; stop_bits = 1'b1;
      send_frame(8'h55, 7, 1, 0, 0);
      check_word("par55");
      consume("par55");

      // Framing error, then a clean frame clears it
      clk_div = 16'd0; data_bits = 2'b11; par_enable = 1'b0; stop_bits = 1'b0;
      send_frame(8'h3C, 8, 0, 1, 0);
      check_word("frm3c");
      consume("frm3c");
      chk("frm_hold", frm_err, 1);
      chk("data_hold", rx_data, 8'h3C);
      send_frame(8'h81, 8, 0, 0, 0);
      check_word("ok81");
      consume("ok81");

      // Overrun, then completion coinciding with consumption
      send_frame(8'h11, 8, 0, 0, 0);
      check_word("ov11");
      send_frame(8'h22, 8, 0, 0, 0);
      check_word("ov22");
      send_frame(8'h33, 8, 0, 0, 0);
      check_word("ov33");
      send_frame(8'h44, 8, 0, 0, 1);
      check_word("rdy44");
      consume("rdy44");

      // Short low glitch on the line
      base = rise_cnt;
      @(negedge clk);
      spi_MISO = 1'b0;
      repeat (5 * (int'(clk_div) + 1)) @(negedge clk);
      spi_MISO = 1'b1;
      chk("glitch_busy", busy, 1);
      repeat (16 * (int'(clk_div) + 1)) @(negedge clk);
      chk("glitch_idle", busy, 0);
      chk("glitch_valid", rx_valid, 0);
      chk("glitch_rises", rise_cnt - base, 0);

      // Enable dropped mid-data leaves the held word alone
      send_frame(8'h5A, 8, 0, 0, 0);
      check_word("hold5a");
      @(negedge clk);
      spi_MISO = 1'b0;
      repeat (16 * 3) @(negedge clk);
      chk("en_busy", busy, 1);
      enable = 1'b0;
      @(negedge clk);
      chk("en_drop_busy", busy, 0);
      chk("en_drop_valid", rx_valid, m_valid);
      chk("en_drop_data", rx_data, 8'h5A);
      spi_MISO = 1'b1;
      repeat (8) @(negedge clk);
      enable = 1'b1;
      repeat (4) @(negedge clk);

      // Reset mid-frame, then a 5-bit odd-parity frame
      spi_MISO = 1'b0;
      repeat (16 * 3) @(negedge clk);
      chk("rst_busy", busy, 1);
      rst = 1'b0;
      @(negedge clk);
      check_all_zero("midrst");
      spi_MISO = 1'b1;
      m_valid  = 1'b0;
      data_bits = 2'b00; par_enable = 1'b1; par_type = 2'b01; stop_bits = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      send_frame(8'h1F, 5, 0, 0, 0);
      check_word("odd1f");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
